// File: rtl/audio_sample_fifo_pkg.sv
// Shared types and defaults for the stereo audio sample FIFO.
//
// Contents:
//   DefFifoWidth / DefAudBitDepth / DefPrimeLevel : default build parameters
//   DEPTH    : default depth in sample pairs (2**DefFifoWidth)
//   pair_t   : stereo pair, packed {left, right}
//   state_e  : delivery state, StPrime (buffering) / StRun (delivering)
//   sat_inc16: saturating 16-bit increment used by the optional event counters
package audio_sample_fifo_pkg;

    localparam int unsigned DefFifoWidth   = 6;
    localparam int unsigned DefAudBitDepth = 24;
    localparam int unsigned DefPrimeLevel  = 8;
    localparam int unsigned DEPTH          = 2 ** DefFifoWidth;

    typedef struct packed {
        logic [DefAudBitDepth-1:0] left;
        logic [DefAudBitDepth-1:0] right;
    } pair_t;

    typedef enum logic [0:0] {
        StPrime,
        StRun
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// Bus bundle between the synth voice output / audio mux and audio_sample_fifo.
//
// Signals:
//   wr_en, lsample_in, rsample_in      : push side (one pair per cycle high)
//   l_read, r_read                      : mux read strobes; r_read pops the head
//   flush, clr_flags                    : control
//   lsound_out, rsound_out              : head pair, or 0
//   level, full, empty, primed          : fill status
//   write_cnt, read_cnt                 : free-running 7-bit push/pop counters
//   underrun, overrun                   : sticky error flags
//   underrun_count, overrun_count       : only with AUDIO_FIFO_STATS_EN defined
// Modports: slave (FIFO side), master (driver side).
interface audio_sample_fifo_if
    import audio_sample_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH    = DefFifoWidth,
    parameter int unsigned AUD_BIT_DEPTH = DefAudBitDepth
) ();

    logic                     wr_en;
    logic [AUD_BIT_DEPTH-1:0] lsample_in;
    logic [AUD_BIT_DEPTH-1:0] rsample_in;
    logic                     l_read;
    logic                     r_read;
    logic                     flush;
    logic                     clr_flags;
    logic [AUD_BIT_DEPTH-1:0] lsound_out;
    logic [AUD_BIT_DEPTH-1:0] rsound_out;
    logic [FIFO_WIDTH:0]      level;
    logic                     full;
    logic                     empty;
    logic                     primed;
    logic [6:0]               write_cnt;
    logic [6:0]               read_cnt;
    logic                     underrun;
    logic                     overrun;
`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0]              underrun_count;
    logic [15:0]              overrun_count;
`endif

    modport slave (
`ifdef AUDIO_FIFO_STATS_EN
        output underrun_count,
        output overrun_count,
`endif
        input  wr_en,
        input  lsample_in,
        input  rsample_in,
        input  l_read,
        input  r_read,
        input  flush,
        input  clr_flags,
        output lsound_out,
        output rsound_out,
        output level,
        output full,
        output empty,
        output primed,
        output write_cnt,
        output read_cnt,
        output underrun,
        output overrun
    );

    modport master (
`ifdef AUDIO_FIFO_STATS_EN
        input  underrun_count,
        input  overrun_count,
`endif
        output wr_en,
        output lsample_in,
        output rsample_in,
        output l_read,
        output r_read,
        output flush,
        output clr_flags,
        input  lsound_out,
        input  rsound_out,
        input  level,
        input  full,
        input  empty,
        input  primed,
        input  write_cnt,
        input  read_cnt,
        input  underrun,
        input  overrun
    );

endinterface

// File: rtl/audio_pair_ram.sv
// Simple dual-port storage for stereo sample pairs.
// Synchronous write, asynchronous (combinational) read; no reset on contents.
//
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data (packed {left, right})
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module audio_pair_ram
    import audio_sample_fifo_pkg::*;
#(
    parameter int unsigned AddrWidth = DefFifoWidth,
    parameter int unsigned DataWidth = 2 * DefAudBitDepth
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [2**AddrWidth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO feeding the audio bus mux.
//
// Buffers {left,right} pairs from the synth voice output, withholds data until
// PRIME_LEVEL pairs are stored, then presents the head pair combinationally;
// r_read pops it, l_read only observes it. An r_read on an empty FIFO while
// running flags underrun and drops back to priming.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : audio_sample_fifo_if.slave (push/read strobes, head pair, status)
//
// Parameters must match those of the connected interface instance.
// Optional feature: define AUDIO_FIFO_STATS_EN to add saturating 16-bit
// underrun_count / overrun_count event counters on the interface.
module audio_sample_fifo
    import audio_sample_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH    = DefFifoWidth,
    parameter int unsigned AUD_BIT_DEPTH = DefAudBitDepth,
    parameter int unsigned PRIME_LEVEL   = DefPrimeLevel
) (
    input  logic                clk,
    input  logic                reset,
    audio_sample_fifo_if.slave  bus
);

    localparam int unsigned       Depth     = 2 ** FIFO_WIDTH;
    localparam int unsigned       PairWidth = 2 * AUD_BIT_DEPTH;
    localparam logic [FIFO_WIDTH:0] LevelFull = (FIFO_WIDTH + 1)'(Depth);

    state_e                  state_q, state_d;
    logic [FIFO_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_WIDTH:0]     level_q, level_d;
    logic [6:0]              write_cnt_q, write_cnt_d;
    logic [6:0]              read_cnt_q, read_cnt_d;
    logic                    underrun_q, underrun_d;
    logic                    overrun_q, overrun_d;

    logic                    empty;
    logic                    full;
    logic                    running;
    logic                    do_pop;
    logic                    do_push;
    logic                    underrun_evt;
    logic                    overrun_evt;
    logic [PairWidth-1:0]    head_pair;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LevelFull);
    assign running = (state_q == StRun);

    // flush overrides any push/pop/flag event in the same cycle.
    always_comb begin
        do_pop       = 1'b0;
        do_push      = 1'b0;
        underrun_evt = 1'b0;
        overrun_evt  = 1'b0;
        if (!bus.flush) begin
            do_pop       = running && bus.r_read && !empty;
            underrun_evt = running && bus.r_read && empty;
            // A full FIFO still accepts a push when a pop frees a slot this cycle.
            do_push      = bus.wr_en && (!full || do_pop);
            overrun_evt  = bus.wr_en && full && !do_pop;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        write_cnt_d = write_cnt_q;
        read_cnt_d  = read_cnt_q;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;

        if (bus.flush) begin
            state_d    = StPrime;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d    = wr_ptr_q + 1'b1;
                write_cnt_d = write_cnt_q + 7'd1;
            end
            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                read_cnt_d = read_cnt_q + 7'd1;
            end
            if (do_push && !do_pop) begin
                level_d = level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_d = level_q - 1'b1;
            end

            unique case (state_q)
                StPrime: begin
                    // Uses the registered level, so priming completes the cycle
                    // after the threshold pair lands.
                    if (32'(level_q) >= PRIME_LEVEL) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (underrun_evt) begin
                        state_d = StPrime;
                    end
                end
                default: state_d = StPrime;
            endcase

            // Set has priority over clear.
            if (underrun_evt) begin
                underrun_d = 1'b1;
            end else if (bus.clr_flags) begin
                underrun_d = 1'b0;
            end
            if (overrun_evt) begin
                overrun_d = 1'b1;
            end else if (bus.clr_flags) begin
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StPrime;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            write_cnt_q <= '0;
            read_cnt_q  <= '0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            write_cnt_q <= write_cnt_d;
            read_cnt_q  <= read_cnt_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    audio_pair_ram #(
        .AddrWidth (FIFO_WIDTH),
        .DataWidth (PairWidth)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.lsample_in, bus.rsample_in}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_pair)
    );

    // Head pair is only exposed while delivering; otherwise the mux sees silence.
    assign bus.lsound_out = (running && !empty) ? head_pair[PairWidth-1:AUD_BIT_DEPTH] : '0;
    assign bus.rsound_out = (running && !empty) ? head_pair[AUD_BIT_DEPTH-1:0] : '0;
    assign bus.level      = level_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.primed     = running;
    assign bus.write_cnt  = write_cnt_q;
    assign bus.read_cnt   = read_cnt_q;
    assign bus.underrun   = underrun_q;
    assign bus.overrun    = overrun_q;

`ifdef AUDIO_FIFO_STATS_EN
    logic [15:0] underrun_count_q, underrun_count_d;
    logic [15:0] overrun_count_q, overrun_count_d;

    always_comb begin
        underrun_count_d = underrun_count_q;
        overrun_count_d  = overrun_count_q;
        if (bus.flush) begin
            underrun_count_d = '0;
            overrun_count_d  = '0;
        end else begin
            if (bus.clr_flags) begin
                underrun_count_d = '0;
                overrun_count_d  = '0;
            end
            if (underrun_evt) begin
                underrun_count_d = sat_inc16(underrun_count_d);
            end
            if (overrun_evt) begin
                overrun_count_d = sat_inc16(overrun_count_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count_q <= '0;
            overrun_count_q  <= '0;
        end else begin
            underrun_count_q <= underrun_count_d;
            overrun_count_q  <= overrun_count_d;
        end
    end

    assign bus.underrun_count = underrun_count_q;
    assign bus.overrun_count  = overrun_count_q;
`endif

endmodule
